// File: rtl/scan_sequencer_pkg.sv
// Shared constants for the row scan sequencer.
// State codes and row geometry used by the FSM and the row finder.
package scan_sequencer_pkg;

    localparam int ROWS  = 16;
    localparam int ROW_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/scan_sequencer_next_row_finder.sv
// Priority search for the lowest unmasked row above a base index,
// or from row 0 when from_zero is set.
module next_row_finder
    import scan_sequencer_pkg::*;
(
    input  logic [ROWS-1:0]  mask,
    input  logic [ROW_W-1:0] base,
    input  logic             from_zero,
    output logic [ROW_W-1:0] row,
    output logic             valid
);

    // Walk downwards so the lowest qualifying index wins.
    always_comb begin
        row   = '0;
        valid = 1'b0;
        for (int k = ROWS - 1; k >= 0; k--) begin
            if (!mask[k] && (from_zero || k > int'(base))) begin
                row   = ROW_W'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Row scan sequencer driving a 4-to-16 one-hot decoder.
// Dwell per row, blanking gap between rows, skip mask, abort.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [ROWS-1:0]  mask,
    output logic [ROW_W-1:0] sel,
    output logic             en,
    output logic             busy,
    output logic             row_done,
    output logic             frame_done
);

    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] GLAST = CW'(GAP - 1);
    localparam logic [CW-1:0] GPEN  = CW'((GAP > 1) ? GAP - 2 : 0);
    localparam bit            GAP1  = (GAP == 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [ROWS-1:0]  mask_q;
    logic             cont_q;

    logic [ROW_W-1:0] nxt_row;
    logic             nxt_ok;
    logic [ROW_W-1:0] first_row;
    logic             first_ok;

    next_row_finder u_nxt (
        .mask      (mask_q),
        .base      (sel),
        .from_zero (1'b0),
        .row       (nxt_row),
        .valid     (nxt_ok)
    );

    next_row_finder u_first (
        .mask      (mask),
        .base      ('0),
        .from_zero (1'b1),
        .row       (first_row),
        .valid     (first_ok)
    );

    assign busy = (state != ST_IDLE);

    // FSM, dwell/gap counter, frame latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            en         <= 1'b0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            mask_q     <= '0;
            cont_q     <= 1'b0;
        end else begin
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            if (stop && state != ST_IDLE) begin
                state <= ST_IDLE;
                en    <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            mask_q <= mask;
                            cont_q <= cont;
                            cnt    <= '0;
                            if (first_ok) begin
                                state <= ST_DWELL;
                                sel   <= first_row;
                                en    <= 1'b1;
                            end else begin
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    ST_DWELL: begin
                        if (cnt == DLAST) begin
                            state    <= ST_GAP;
                            en       <= 1'b0;
                            cnt      <= '0;
                            row_done <= 1'b1;
                            if (GAP1 && !nxt_ok)
                                frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (cnt == GLAST) begin
                            cnt <= '0;
                            if (nxt_ok) begin
                                state <= ST_DWELL;
                                sel   <= nxt_row;
                                en    <= 1'b1;
                            end else if (cont_q) begin
                                mask_q <= mask;
                                if (first_ok) begin
                                    state <= ST_DWELL;
                                    sel   <= first_row;
                                    en    <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (!GAP1 && cnt == GPEN && !nxt_ok)
                                frame_done <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        en    <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer.
// Compares every cycle against a per-frame schedule built from the rules.
module tb_scan_sequencer;

    localparam int DW = 4;
    localparam int GP = 1;

    typedef struct packed {
        logic [3:0] sel;
        logic       en;
        logic       busy;
        logic       rd;
        logic       fd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic [15:0] mask = '0;
    logic [3:0]  sel;
    logic        en;
    logic        busy;
    logic        row_done;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    obs_t exp_q[$];

    scan_sequencer #(.DWELL(DW), .GAP(GP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .mask       (mask),
        .sel        (sel),
        .en         (en),
        .busy       (busy),
        .row_done   (row_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic obs_t now();
        obs_t o;
        o.sel  = sel;
        o.en   = en;
        o.busy = busy;
        o.rd   = row_done;
        o.fd   = frame_done;
        return o;
    endfunction

    // Reference schedule: each unmasked row in ascending order gets DW
    // enabled cycles then GP blank cycles; row_done on the first blank
    // cycle, frame_done on the final blank cycle of the last row.
    task automatic add_frame(input logic [15:0] m);
        int   last;
        obs_t e;
        last = -1;
        for (int r = 0; r < 16; r++)
            if (!m[r]) last = r;
        for (int r = 0; r < 16; r++) begin
            if (!m[r]) begin
                for (int d = 0; d < DW; d++) begin
                    e.sel = 4'(r); e.en = 1'b1; e.busy = 1'b1;
                    e.rd = 1'b0; e.fd = 1'b0;
                    exp_q.push_back(e);
                end
                for (int g = 0; g < GP; g++) begin
                    e.sel = 4'(r); e.en = 1'b0; e.busy = 1'b1;
                    e.rd = (g == 0); e.fd = (r == last) && (g == GP - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic add_idle(input logic [3:0] s);
        obs_t e;
        e = '0;
        e.sel = s;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] last_row(input logic [15:0] m);
        logic [3:0] l;
        l = 4'd0;
        for (int r = 0; r < 16; r++)
            if (!m[r]) l = 4'(r);
        return l;
    endfunction

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        o = now();
        total++;
        if (o !== obs_t'(0)) begin
            bad++;
            $display("FAIL reset_state got %h want %h", o, obs_t'(0));
        end
        mask = 16'h001F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (sel !== 4'd5 || en !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_row5 got sel=%0d en=%b want sel=5 en=1", sel, en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            o = now();
            total++;
            if (o !== obs_t'(0)) begin
                bad++;
                $display("FAIL reset_mid_dwell c%0d got %h want %h", i, o, obs_t'(0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_frame();
        obs_t o;
        int   nbusy, nrd, nfd;
        exp_q.delete();
        add_frame(16'h0000);
        add_idle(4'd15);
        nbusy = 0; nrd = 0; nfd = 0;
        mask = 16'h0000; cont = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = now();
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL single_frame c%0d got %h want %h", i, o, exp_q[i]);
            end
            nbusy += int'(busy);
            nrd   += int'(row_done);
            nfd   += int'(frame_done);
            @(negedge clk);
        end
        total++;
        if (nbusy != 80) begin
            bad++;
            $display("FAIL single_busy_len got %0d want 80", nbusy);
        end
        total++;
        if (nrd != 16) begin
            bad++;
            $display("FAIL single_row_done got %0d want 16", nrd);
        end
        total++;
        if (nfd != 1) begin
            bad++;
            $display("FAIL single_frame_done got %0d want 1", nfd);
        end
    endtask

    task automatic test_sparse_mask();
        obs_t o;
        int   nbusy, nrd;
        exp_q.delete();
        add_frame(16'h7FFE);
        add_idle(4'd15);
        nbusy = 0; nrd = 0;
        mask = 16'h7FFE; cont = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = now();
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL sparse_mask c%0d got %h want %h", i, o, exp_q[i]);
            end
            nbusy += int'(busy);
            nrd   += int'(row_done);
            @(negedge clk);
        end
        total++;
        if (nbusy != 10 || nrd != 2) begin
            bad++;
            $display("FAIL sparse_len got busy=%0d rd=%0d want busy=10 rd=2", nbusy, nrd);
        end
    endtask

    task automatic test_all_masked();
        logic [3:0] got;
        mask = 16'hFFFF; cont = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = {en, busy, row_done, frame_done};
        total++;
        if (got !== 4'b0001) begin
            bad++;
            $display("FAIL all_masked_pulse got %b want 0001", got);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {en, busy, row_done, frame_done};
            total++;
            if (got !== 4'b0000) begin
                bad++;
                $display("FAIL all_masked_after c%0d got %b want 0000", i, got);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        logic [3:0] got;
        mask = 16'h0000; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            got = {en, busy, row_done, frame_done};
            total++;
            if (got !== 4'b0000) begin
                bad++;
                $display("FAIL start_stop_idle c%0d got %b want 0000", i, got);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cont_stop();
        obs_t o;
        obs_t e;
        int   n;
        exp_q.delete();
        add_frame(16'h0000);
        add_frame(16'h00FF);
        n = 80 + 2 * (DW + GP) + 2;
        mask = 16'h0000; cont = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cont = 1'b0;
        for (int i = 0; i < n; i++) begin
            o = now();
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL cont_frames c%0d got %h want %h", i, o, exp_q[i]);
            end
            if (i < 80 && exp_q[i].sel == 4'd3)
                mask = 16'h00FF;
            if (i == n - 1)
                stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        e = '0;
        e.sel = 4'd10;
        for (int i = 0; i < 3; i++) begin
            o = now();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL cont_stop c%0d got %h want %h", i, o, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        obs_t        o;
        logic [15:0] m;
        for (int it = 0; it < 6; it++) begin
            m = 16'($urandom);
            if (m == 16'hFFFF)
                m[$urandom_range(15, 0)] = 1'b0;
            exp_q.delete();
            add_frame(m);
            add_idle(last_row(m));
            mask = m; cont = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                o = now();
                total++;
                if (o !== exp_q[i]) begin
                    bad++;
                    $display("FAIL back_to_back f%0d c%0d got %h want %h", it, i, o, exp_q[i]);
                end
                if (i < exp_q.size() - 1) begin
                    start = ($urandom_range(3, 0) == 0);
                    cont  = 1'($urandom);
                    mask  = 16'($urandom);
                end else begin
                    start = 1'b0;
                    cont  = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_sparse_mask();
        test_all_masked();
        test_start_stop_idle();
        test_cont_stop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequential address generator that drives the select and enable inputs of the team's 4-to-16 one-hot decoder.
- Steps through up to 16 rows, holds each for a programmable dwell time, and inserts blanking between rows so no two decoder outputs are ever active together.
- Supports single-frame and continuous scanning, a per-row skip mask, and an abort.
- Sits directly upstream of the decoder: sel connects to its 4-bit input and en to its enable.

Parameters:
- DWELL, 4, cycles en is held high per row (≥1).
- GAP, 1, blanking cycles with en low between rows (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; accepted only in IDLE.
- stop  in  1  abort scan; honoured in any state.
- cont  in  1  1 = continuous frames, 0 = single frame; sampled with start.
- mask  in  16  bit k = 1 skips row k; latched at each frame start.
- sel  out  4  row index; value k selects decoder output k.
- en  out  1  decoder enable.
- busy  out  1  high whenever the state is not IDLE.
- row_done  out  1  one-cycle pulse after each row's dwell ends.
- frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE.
  - sel=0, en=0, busy=0, row_done=0, frame_done=0.
  - Dwell/gap counter=0; latched mask=0; latched cont=0.
  - rst has priority over all other inputs, including mid-frame.
- All outputs are registered.
- States: IDLE, DWELL, GAP.
- IDLE:
  - start=1 and stop=0 → latch mask and cont, then search for the first unmasked row from index 0.
  - If a row is found → DWELL with sel=row. en=1 and busy=1 appear in the cycle after start (1-cycle latency).
  - If mask=16'hFFFF → remain IDLE, pulse frame_done next cycle, en stays 0.
- DWELL:
  - en=1 for exactly DWELL consecutive cycles; the counter runs 0..DWELL-1.
  - sel is constant throughout.
  - After the last dwell cycle → GAP: en=0, row_done=1 for the first GAP cycle only, sel unchanged.
- GAP:
  - en=0 for exactly GAP cycles.
  - Next row = lowest unmasked index strictly greater than sel.
  - If a next row exists → DWELL with the new sel. sel changes only on the GAP→DWELL transition, never while en=1.
  - If none exists (frame end) → frame_done=1 in the last GAP cycle.
    - cont=1: re-latch mask from the input, restart the search from 0. Same all-masked rule as IDLE, except with cont=1 the block returns to IDLE.
    - cont=0: → IDLE with busy=0 on the next cycle.
- stop:
  - Any non-IDLE state → IDLE next cycle. en=0, no row_done or frame_done pulse, sel retains its last value.
  - stop and start together in IDLE → start ignored.
- start while busy: ignored.
- Mask changes mid-frame: no effect until the next frame latch.
- Invariants:
  - en and GAP state are mutually exclusive.
  - row_done and frame_done are each at most one cycle wide.
  - Frame length in cycles = (unmasked rows) × (DWELL + GAP).
- Counter width: clog2(max(DWELL,GAP)) bits, minimum 1. The counter wraps only through explicit reset to 0 on state change.

Decomposition:
- Shared package: state enum (IDLE, DWELL, GAP), ROWS=16 and ROW_W=4 constants.
- One natural sub-module: next_row_finder. Combinational priority search returning the lowest unmasked index greater than a base (or from 0), plus a valid flag.
- Top level instantiates next_row_finder and the FSM/counter.

Test Plan:
- Reset mid-DWELL on row 5:
  - Stimulus: assert rst for 1 cycle.
  - Required response: next cycle state IDLE, sel=0, en=0, busy=0, no done pulses.
- Single frame, DWELL=4, GAP=1, mask=0:
  - Stimulus: start.
  - Required response: en high 4 cycles per row, sel sequence 0..15, 16 row_done pulses, frame_done once, busy low after exactly 80 cycles. Decoder output k is high only while sel=k and en=1.
- mask=16'h7FFE, cont=0:
  - Stimulus: start.
  - Required response: only rows 0 and 15 driven, 2 row_done pulses, frame length 10 cycles.
- mask=16'hFFFF:
  - Stimulus: start.
  - Required response: busy stays 0, en stays 0, single frame_done pulse one cycle after start.
- cont=1, mask=0:
  - Stimulus: start; change mask to 16'h00FF during row 3.
  - Required response: first frame covers all 16 rows; second frame begins at sel=8. Assert stop in row 10's dwell → en=0 and busy=0 next cycle, no frame_done.
- Simultaneous start and stop in IDLE:
  - Required response: stays IDLE.
- start asserted while busy:
  - Required response: no change to sel sequence or timing.
